// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory stage.
//   word_t     - 32-bit machine word
//   memstate_t - memory-stage FSM state (IDLE/REQ/DONE)
//   memreq_t   - request captured from the EX/MEM latch
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memstate_t;

    typedef struct packed {
        word_t addr;
        word_t data;
        logic  store;
        logic  atomic;
    } memreq_t;

    localparam logic [7:0] WAIT_MAX = 8'hFF;

    // Reservations are tracked per word, so the byte offset is dropped.
    function automatic logic [29:0] word_idx(input word_t a);
        return a[31:2];
    endfunction

endpackage

// File: rtl/llsc_link.sv
// llsc_link: load-linked reservation register with SC match and snoop invalidate.
//   clk, rst_n           - clock, asynchronous active-low reset
//   ll_done              - LL completed; reserve done_idx
//   st_done              - plain store completed to done_idx
//   sc_done              - successful SC completed; drop reservation
//   done_idx             - word index of the completing access
//   chk_idx              - word index of the SC being evaluated
//   ccinv, snoop_idx     - coherence invalidate and its word index
//   sc_ok                - SC at chk_idx may proceed this cycle
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ll_done,
    input  logic        st_done,
    input  logic        sc_done,
    input  logic [29:0] done_idx,
    input  logic [29:0] chk_idx,
    input  logic        ccinv,
    input  logic [29:0] snoop_idx,
    output logic        sc_ok
);

    logic        link_valid;
    logic [29:0] link_addr;
    logic        inv_hit;

    assign inv_hit = ccinv && snoop_idx == link_addr;
    // A same-cycle invalidate beats the SC check.
    assign sc_ok   = link_valid && link_addr == chk_idx && !inv_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (ll_done) begin
            // A snoop to the word being reserved kills the new reservation.
            link_valid <= !(ccinv && snoop_idx == done_idx);
            link_addr  <= done_idx;
        end else if (inv_hit || sc_done || (st_done && done_idx == link_addr)) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage driving the data cache, with LL/SC support.
//   CLK, nRST                 - clock, asynchronous active-low reset
//   dMemREN_in, dMemWEN_in    - load / store request from EX/MEM
//   Atomic_in                 - LL with REN, SC with WEN
//   addr_in, store_in         - effective address, store data
//   flush                     - discard a request not yet issued
//   dhit, dmemload            - cache completion and read data
//   ccinv, ccsnoopaddr        - coherence invalidate and address
//   dmemREN, dmemWEN          - cache request
//   dmemaddr, dmemstore       - cache address and store data
//   load_out                  - load data, or SC status (1 pass / 0 fail)
//   done_out                  - one-cycle completion pulse
//   stall_out                 - holds the upstream latch
//   wait_cnt                  - saturating dhit wait cycles of current access
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dMemREN_in,
    input  logic        dMemWEN_in,
    input  logic        Atomic_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_in,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] load_out,
    output logic        done_out,
    output logic        stall_out,
    output logic [7:0]  wait_cnt
);

    memstate_t state;
    memreq_t   req;
    logic      req_valid;
    logic      is_sc;
    logic      sc_ok;
    logic      complete;
    logic      unused;

    assign req_valid = (dMemREN_in || dMemWEN_in) && !flush;
    // REN+WEN together is a store, so WEN alone decides the op.
    assign is_sc     = Atomic_in && dMemWEN_in;
    assign complete  = state == REQ && dhit;
    assign unused    = ^ccsnoopaddr[1:0];

    assign dmemREN   = state == REQ && !req.store;
    assign dmemWEN   = state == REQ && req.store;
    assign dmemaddr  = req.addr;
    assign dmemstore = req.data;
    assign done_out  = state == DONE;
    assign stall_out = state == REQ || (state == IDLE && req_valid);

    llsc_link u_link (
        .clk      (CLK),
        .rst_n    (nRST),
        .ll_done  (complete && !req.store && req.atomic),
        .st_done  (complete && req.store && !req.atomic),
        .sc_done  (complete && req.store && req.atomic),
        .done_idx (word_idx(req.addr)),
        .chk_idx  (word_idx(addr_in)),
        .ccinv    (ccinv),
        .snoop_idx(word_idx(ccsnoopaddr)),
        .sc_ok    (sc_ok)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            req      <= '0;
            load_out <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req <= '{addr: addr_in, data: store_in, store: dMemWEN_in, atomic: Atomic_in};
                    if (is_sc && !sc_ok) begin
                        // Failed SC never touches memory.
                        state    <= DONE;
                        load_out <= '0;
                    end else begin
                        state    <= REQ;
                        wait_cnt <= '0;
                    end
                end
                REQ: if (dhit) begin
                    state <= DONE;
                    if (!req.store)
                        load_out <= dmemload;
                    else if (req.atomic)
                        load_out <= 32'd1;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage.
module tb_mem_stage;

    logic        CLK = 0;
    logic        nRST;
    logic        dMemREN_in, dMemWEN_in, Atomic_in, flush, dhit, ccinv;
    logic [31:0] addr_in, store_in, dmemload, ccsnoopaddr;
    logic        dmemREN, dmemWEN, done_out, stall_out;
    logic [31:0] dmemaddr, dmemstore, load_out;
    logic [7:0]  wait_cnt;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .CLK(CLK), .nRST(nRST),
        .dMemREN_in(dMemREN_in), .dMemWEN_in(dMemWEN_in), .Atomic_in(Atomic_in),
        .addr_in(addr_in), .store_in(store_in), .flush(flush),
        .dhit(dhit), .dmemload(dmemload),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .load_out(load_out), .done_out(done_out), .stall_out(stall_out), .wait_cnt(wait_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren, wen, at, inv, fl;
        logic [31:0] addr, data, rdata;
        int          waits;
        logic        exp_wen;
        logic        exp_mem;
        logic [31:0] exp_load;
    } vec_t;

    typedef struct {
        logic [31:0] load;
        logic [7:0]  wc;
        logic        mem;
        int          ncyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[17];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic ren, wen, at, inv, fl, input logic [31:0] addr, data,
                                input int waits, input logic [31:0] rdata,
                                input logic exp_wen, exp_mem, input logic [31:0] exp_load);
        vec_t v;
        v.ren = ren; v.wen = wen; v.at = at; v.inv = inv; v.fl = fl;
        v.addr = addr; v.data = data; v.waits = waits; v.rdata = rdata;
        v.exp_wen = exp_wen; v.exp_mem = exp_mem; v.exp_load = exp_load;
        return v;
    endfunction

    task automatic idle_inputs();
        dMemREN_in = 0; dMemWEN_in = 0; Atomic_in = 0; ccinv = 0; flush = 0;
        dhit = 0;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        exp_t e;
        exp_t g;
        int   n;
        bit   got;
        @(negedge CLK);
        dMemREN_in = v.ren; dMemWEN_in = v.wen; Atomic_in = v.at;
        addr_in = v.addr; store_in = v.data;
        ccinv = v.inv; ccsnoopaddr = v.addr;
        #1 check({nm, ":stall_on_req"}, {31'd0, stall_out}, 32'd1);
        e.load = v.exp_load;
        e.wc   = v.waits > 255 ? 8'd255 : 8'(v.waits);
        e.mem  = v.exp_mem;
        e.ncyc = v.exp_mem ? v.waits + 1 : 0;
        sb.push_back(e);
        n = 0;
        got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge CLK);
            dMemREN_in = 0; dMemWEN_in = 0; Atomic_in = 0; ccinv = 0;
            addr_in = 32'hFFFF_FFF0; store_in = 32'h0BAD_0BAD;
            flush = v.fl;
            if (done_out) begin
                got = 1;
                g = sb.pop_front();
                check({nm, ":load_out"}, load_out, g.load);
                if (g.mem) check({nm, ":wait_cnt"}, {24'd0, wait_cnt}, {24'd0, g.wc});
                check({nm, ":req_cycles"}, n, g.ncyc);
                check({nm, ":stall_in_done"}, {31'd0, stall_out}, 32'd0);
                dhit = 0;
                flush = 0;
            end else begin
                n++;
                check({nm, ":dmemREN"}, {31'd0, dmemREN}, {31'd0, !v.exp_wen});
                check({nm, ":dmemWEN"}, {31'd0, dmemWEN}, {31'd0, v.exp_wen});
                check({nm, ":dmemaddr"}, dmemaddr, v.addr);
                if (v.exp_wen) check({nm, ":dmemstore"}, dmemstore, v.data);
                check({nm, ":stall_in_req"}, {31'd0, stall_out}, 32'd1);
                dhit = (n == v.waits + 1);
                dmemload = v.rdata;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL %s:timeout got no done_out expected done_out", nm);
        end else begin
            @(negedge CLK);
            check({nm, ":done_single_pulse"}, {31'd0, done_out}, 32'd0);
        end
    endtask

    task automatic pulse_inv(input logic [31:0] a);
        @(negedge CLK);
        ccinv = 1; ccsnoopaddr = a;
        @(negedge CLK);
        ccinv = 0;
    endtask

    initial begin
        nRST = 0;
        idle_inputs();
        addr_in = 0; store_in = 0; dmemload = 0; ccsnoopaddr = 0;

        //           ren wen at inv fl addr          data          waits rdata         wen mem load
        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h100, 32'h0,        3,   32'h1234_5678, 0, 1, 32'h1234_5678);
        tbl[1]  = mk(0, 1, 0, 0, 0, 32'h104, 32'hCAFE_F00D, 1,  32'h0,         1, 1, 32'h1234_5678);
        tbl[2]  = mk(1, 0, 1, 0, 0, 32'h200, 32'h0,        0,   32'h0BAD_BEEF, 0, 1, 32'h0BAD_BEEF);
        tbl[3]  = mk(0, 1, 1, 0, 0, 32'h200, 32'hDEAD,     2,   32'h0,         1, 1, 32'h1);
        tbl[4]  = mk(0, 1, 1, 0, 0, 32'h200, 32'hBEEF,     0,   32'h0,         1, 0, 32'h0);
        tbl[5]  = mk(1, 0, 1, 0, 0, 32'h300, 32'h0,        0,   32'h33,        0, 1, 32'h33);
        tbl[6]  = mk(0, 1, 0, 0, 0, 32'h300, 32'h5,        0,   32'h0,         1, 1, 32'h33);
        tbl[7]  = mk(0, 1, 1, 0, 0, 32'h300, 32'h6,        0,   32'h0,         1, 0, 32'h0);
        tbl[8]  = mk(1, 1, 0, 0, 0, 32'h108, 32'h77,       1,   32'hFFFF_FFFF, 1, 1, 32'h0);
        tbl[9]  = mk(1, 0, 1, 0, 0, 32'h400, 32'h0,        0,   32'h44,        0, 1, 32'h44);
        tbl[10] = mk(0, 1, 1, 0, 0, 32'h404, 32'h88,       0,   32'h0,         1, 0, 32'h0);
        tbl[11] = mk(0, 1, 1, 0, 0, 32'h400, 32'h99,       0,   32'h0,         1, 1, 32'h1);
        tbl[12] = mk(1, 0, 1, 0, 0, 32'h200, 32'h0,        0,   32'h22,        0, 1, 32'h22);
        tbl[13] = mk(0, 1, 1, 1, 0, 32'h200, 32'hAA,       0,   32'h0,         1, 0, 32'h0);
        tbl[14] = mk(0, 1, 0, 0, 1, 32'h500, 32'h55,       3,   32'h0,         1, 1, 32'h0);
        tbl[15] = mk(1, 0, 0, 0, 0, 32'h600, 32'h0,        260, 32'hA5A5_A5A5, 0, 1, 32'hA5A5_A5A5);
        tbl[16] = mk(1, 0, 0, 0, 0, 32'h604, 32'h0,        0,   32'h5A,        0, 1, 32'h5A);

        repeat (2) @(negedge CLK);
        check("reset:dmemREN", {31'd0, dmemREN}, 32'd0);
        check("reset:dmemWEN", {31'd0, dmemWEN}, 32'd0);
        check("reset:done_out", {31'd0, done_out}, 32'd0);
        check("reset:stall_out", {31'd0, stall_out}, 32'd0);
        check("reset:load_out", load_out, 32'd0);
        check("reset:wait_cnt", {24'd0, wait_cnt}, 32'd0);
        nRST = 1;

        for (int i = 0; i < 17; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Snoop to a neighbouring word keeps the link; to the linked word kills it.
        run_op(mk(1, 0, 1, 0, 0, 32'h200, 0, 0, 32'h21, 0, 1, 32'h21), "inv_ll_a");
        pulse_inv(32'h204);
        run_op(mk(0, 1, 1, 0, 0, 32'h200, 32'h1, 0, 0, 1, 1, 32'h1), "inv_neighbor_sc_pass");
        run_op(mk(1, 0, 1, 0, 0, 32'h200, 0, 0, 32'h21, 0, 1, 32'h21), "inv_ll_b");
        pulse_inv(32'h204);
        pulse_inv(32'h200);
        run_op(mk(0, 1, 1, 0, 0, 32'h200, 32'h2, 0, 0, 1, 0, 32'h0), "inv_match_sc_fail");

        // Flushed request in IDLE: no stall, no access, link untouched.
        run_op(mk(1, 0, 1, 0, 0, 32'h700, 0, 0, 32'h70, 0, 1, 32'h70), "flush_ll");
        @(negedge CLK);
        dMemWEN_in = 1; Atomic_in = 1; addr_in = 32'h700; flush = 1;
        #1 check("flush_idle:stall", {31'd0, stall_out}, 32'd0);
        @(negedge CLK);
        idle_inputs();
        check("flush_idle:dmemWEN", {31'd0, dmemWEN}, 32'd0);
        check("flush_idle:done", {31'd0, done_out}, 32'd0);
        run_op(mk(0, 1, 1, 0, 0, 32'h700, 32'h7, 0, 0, 1, 1, 32'h1), "flush_idle_sc_pass");

        // Reset in the middle of a pending load.
        run_op(mk(1, 0, 1, 0, 0, 32'h800, 0, 0, 32'h80, 0, 1, 32'h80), "rst_ll");
        @(negedge CLK);
        dMemREN_in = 1; addr_in = 32'h900;
        @(negedge CLK);
        idle_inputs();
        check("rst:in_req", {31'd0, dmemREN}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        #2 nRST = 0;
        #1;
        check("rst:dmemREN", {31'd0, dmemREN}, 32'd0);
        check("rst:dmemWEN", {31'd0, dmemWEN}, 32'd0);
        check("rst:done_out", {31'd0, done_out}, 32'd0);
        check("rst:stall_out", {31'd0, stall_out}, 32'd0);
        check("rst:load_out", load_out, 32'd0);
        check("rst:wait_cnt", {24'd0, wait_cnt}, 32'd0);
        check("rst:dmemaddr", dmemaddr, 32'd0);
        @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        check("rst:no_done_after", {31'd0, done_out}, 32'd0);
        run_op(mk(0, 1, 1, 0, 0, 32'h800, 32'h8, 0, 0, 1, 0, 32'h0), "rst_link_cleared");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
